// File: rtl/game_pkg.sv
// Shared definitions for the game datapath: FSM state encoding, state width
// and the value width used by the LFSR generator, the round controller and
// the display driver.
package game_pkg;

    localparam int STATE_W = 3;
    localparam int VALUE_W = 8;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        WAIT   = 3'd2,
        RESULT = 3'd3,
        DONE   = 3'd4
    } game_state_t;

    // Adds one point to the score when the round was answered correctly.
    function automatic logic [VALUE_W-1:0] score_add(
        input logic [VALUE_W-1:0] score,
        input logic               hit
    );
        return score + {{(VALUE_W-1){1'b0}}, hit};
    endfunction

endpackage

// File: rtl/rising_edge_detect.sv
// Rising-edge detector for an already synchronised, debounced level input.
// The history register updates every cycle, so a held level yields exactly
// one pulse and a new pulse needs a low sample in between.
module rising_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic level_q_r;

    // Remember the previous sample of the level input.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q_r <= 1'b0;
        end else begin
            level_q_r <= level;
        end
    end

    assign pulse = level & ~level_q_r;

endmodule

// File: rtl/binary_round_controller.sv
// Game-round controller: latches an LFSR value as the round target, waits for
// the player's submit, scores the answer, holds the verdict for RESULT_CYCLES
// cycles and ends the game after MAX_ROUNDS rounds.
// Optional feature: define BINARY_ROUND_TIMEOUT_EN to give each round an
// answer window of TIMEOUT_CYCLES cycles; otherwise WAIT waits forever and
// timed_out is constant 0.
module binary_round_controller
    import game_pkg::*;
#(
    parameter int MAX_ROUNDS     = 10,
    parameter int RESULT_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [VALUE_W-1:0]   random,
    input  logic [VALUE_W-1:0]   answer,
    input  logic                 submit,
    input  logic                 start,
    output logic [VALUE_W-1:0]   target,
    output logic [VALUE_W-1:0]   score,
    output logic [VALUE_W-1:0]   round_num,
    output logic [STATE_W-1:0]   state_o,
    output logic                 result_valid,
    output logic                 result_ok,
    output logic                 timed_out,
    output logic                 game_over
);

    localparam int                 RES_W     = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;
    localparam logic [RES_W-1:0]   RES_LAST  = RES_W'(RESULT_CYCLES - 1);
    localparam logic [VALUE_W-1:0] ROUND_MAX = VALUE_W'(MAX_ROUNDS);

    game_state_t          state_r;
    logic [VALUE_W-1:0]   target_r;
    logic [VALUE_W-1:0]   score_r;
    logic [VALUE_W-1:0]   round_r;
    logic [RES_W-1:0]     res_cnt_r;
    logic                 valid_r;
    logic                 ok_r;
    logic                 over_r;
    logic                 submit_e_s;
    logic                 start_e_s;

    rising_edge_detect u_submit_edge (
        .clk   (clk),
        .rst   (rst),
        .level (submit),
        .pulse (submit_e_s)
    );

    rising_edge_detect u_start_edge (
        .clk   (clk),
        .rst   (rst),
        .level (start),
        .pulse (start_e_s)
    );

`ifdef BINARY_ROUND_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_r;
    logic             timed_out_r;
`else
    // TIMEOUT_CYCLES only matters with the answer window enabled; this
    // elaboration-time range guard keeps it referenced in every build.
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_range_guard
    end
`endif

    // Round FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            target_r  <= '0;
            score_r   <= '0;
            round_r   <= '0;
            res_cnt_r <= '0;
            valid_r   <= 1'b0;
            ok_r      <= 1'b0;
            over_r    <= 1'b0;
`ifdef BINARY_ROUND_TIMEOUT_EN
            tmo_cnt_r   <= '0;
            timed_out_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    // A new game starts from either the idle or the finished state.
                    if (start_e_s) begin
                        score_r <= '0;
                        round_r <= '0;
                        valid_r <= 1'b0;
                        ok_r    <= 1'b0;
                        over_r  <= 1'b0;
`ifdef BINARY_ROUND_TIMEOUT_EN
                        timed_out_r <= 1'b0;
`endif
                        state_r <= LOAD;
                    end
                end
                LOAD: begin
                    target_r <= random;
`ifdef BINARY_ROUND_TIMEOUT_EN
                    tmo_cnt_r   <= TMO_LOAD;
                    timed_out_r <= 1'b0;
`endif
                    state_r  <= WAIT;
                end
                WAIT: begin
                    // A submit edge always wins over an expiring answer window.
                    if (submit_e_s) begin
                        ok_r      <= (answer == target_r);
                        score_r   <= score_add(score_r, answer == target_r);
                        valid_r   <= 1'b1;
                        res_cnt_r <= '0;
                        state_r   <= RESULT;
`ifdef BINARY_ROUND_TIMEOUT_EN
                    end else if (tmo_cnt_r == '0) begin
                        ok_r        <= 1'b0;
                        timed_out_r <= 1'b1;
                        valid_r     <= 1'b1;
                        res_cnt_r   <= '0;
                        state_r     <= RESULT;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r - TMO_W'(1);
`endif
                    end
                end
                RESULT: begin
                    if (res_cnt_r == RES_LAST) begin
                        valid_r <= 1'b0;
                        round_r <= round_r + 8'd1;
                        if ((round_r + 8'd1) == ROUND_MAX) begin
                            over_r  <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            state_r <= LOAD;
                        end
                    end else begin
                        res_cnt_r <= res_cnt_r + RES_W'(1);
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    over_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign target       = target_r;
    assign score        = score_r;
    assign round_num    = round_r;
    assign state_o      = state_r;
    assign result_valid = valid_r;
    assign result_ok    = ok_r;
    assign game_over    = over_r;
`ifdef BINARY_ROUND_TIMEOUT_EN
    assign timed_out    = timed_out_r;
`else
    assign timed_out    = 1'b0;
`endif

endmodule
